// File: rtl/sprite_lane_drawer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sprite_lane_drawer                                               |
// | Purpose : Raster-plots or erases a solid lane sprite on the 160x120 VGA    |
// |           framebuffer, one registered pixel per clock.                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sprite_lane_drawer #(
  parameter int                   NUM_POS     = 4,
  parameter logic [8*NUM_POS-1:0] POS_X_LIST  = 32'h844E1806,
  parameter logic [6:0]           Y_TOP       = 7'd102,
  parameter int                   SPR_W       = 9,
  parameter int                   SPR_H       = 5,
  parameter logic [2:0]           DRAW_COLOR  = 3'b011,
  parameter logic [2:0]           ERASE_COLOR = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Op,
  input  logic [3:0] Pos,
  output logic [7:0] XOut,
  output logic [6:0] YOut,
  output logic [2:0] Color,
  output logic       Plot,
  output logic       Busy,
  output logic       Done
);

  localparam logic [4:0] c_num_pos = 5'(NUM_POS);
  localparam logic [3:0] c_max_pos = 4'(NUM_POS - 1);
  localparam logic [3:0] c_x_max   = 4'(SPR_W - 1);
  localparam logic [2:0] c_y_max   = 3'(SPR_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_xc;
  logic [2:0] r_yc;
  logic [3:0] r_new_pos;
  logic [3:0] r_last_pos;
  logic       r_last_valid;
  logic [1:0] r_op;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_color;
  logic       r_plot;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_scan;
  logic       w_last_px;
  logic [3:0] w_xc_nxt;
  logic [2:0] w_yc_nxt;
  logic [3:0] w_pos_clamped;
  logic [3:0] w_new_pos_nxt;
  logic [3:0] w_sel_nxt;
  logic       w_plot_nxt;
  logic [7:0] w_pos_x [16];

  // Unused table slots read as zero so a 4-bit lane index never runs off the table.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pos
    if (gi < NUM_POS) begin : g_used
      assign w_pos_x[gi] = POS_X_LIST[8*gi +: 8];
    end else begin : g_unused
      assign w_pos_x[gi] = 8'd0;
    end
  end

  assign w_pos_clamped = ({1'b0, Pos} >= c_num_pos) ? c_max_pos : Pos;
  assign w_scan        = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_last_px     = w_scan && (r_xc == c_x_max) && (r_yc == c_y_max);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          if ((Op == 2'b01) || (Op == 2'b10)) begin
            if (r_last_valid) begin
              w_state_nxt = S_ERASE;
            end else if (Op == 2'b10) begin
              w_state_nxt = S_DRAW;
            end else begin
              w_state_nxt = S_FIN;
            end
          end else begin
            w_state_nxt = S_DRAW;
          end
        end
      end
      S_ERASE: begin
        if (w_last_px) begin
          w_state_nxt = (r_op == 2'b10) ? S_DRAW : S_FIN;
        end
      end
      S_DRAW: begin
        if (w_last_px) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counters fall back to zero outside a scan, so entering any scan starts at (0,0).
  always_comb begin
    w_xc_nxt = 4'd0;
    w_yc_nxt = 3'd0;
    if (w_scan && !w_last_px) begin
      if (r_xc == c_x_max) begin
        w_yc_nxt = r_yc + 3'd1;
      end else begin
        w_xc_nxt = r_xc + 4'd1;
        w_yc_nxt = r_yc;
      end
    end
  end

  assign w_new_pos_nxt = w_accept ? w_pos_clamped : r_new_pos;
  assign w_sel_nxt     = (w_state_nxt == S_ERASE) ? r_last_pos : w_new_pos_nxt;
  assign w_plot_nxt    = (w_state_nxt == S_ERASE) || (w_state_nxt == S_DRAW);

  // Outputs are computed from next-state values so the pixel lands the cycle after accept.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_xc         <= 4'd0;
      r_yc         <= 3'd0;
      r_new_pos    <= 4'd0;
      r_last_pos   <= 4'd0;
      r_last_valid <= 1'b0;
      r_op         <= 2'b00;
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_color      <= 3'd0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_xc <= w_xc_nxt;
      r_yc <= w_yc_nxt;
      if (w_accept) begin
        r_new_pos <= w_pos_clamped;
        r_op      <= Op;
      end
      if ((r_state == S_ERASE) && w_last_px) begin
        r_last_valid <= 1'b0;
      end
      if ((r_state == S_DRAW) && w_last_px) begin
        r_last_pos   <= r_new_pos;
        r_last_valid <= 1'b1;
      end
      r_plot <= w_plot_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_FIN);
      if (w_plot_nxt) begin
        r_x     <= w_pos_x[w_sel_nxt] + {4'd0, w_xc_nxt};
        r_y     <= Y_TOP + {4'd0, w_yc_nxt};
        r_color <= (w_state_nxt == S_ERASE) ? ERASE_COLOR : DRAW_COLOR;
      end
    end
  end

  assign XOut  = r_x;
  assign YOut  = r_y;
  assign Color = r_color;
  assign Plot  = r_plot;
  assign Busy  = r_busy;
  assign Done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_lane_drawer.sv
`default_nettype none
// Directed bench for sprite_lane_drawer: pixel scoreboard plus handshake timing checks
// on a default-size instance and a 1x1 sprite instance.
module tb_sprite_lane_drawer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [1:0] Op    = 2'b00;
  logic [3:0] Pos   = 4'd0;
  logic [7:0] XOut;
  logic [6:0] YOut;
  logic [2:0] Color;
  logic       Plot, Busy, Done;

  logic       Start1 = 1'b0;
  logic [1:0] Op1    = 2'b00;
  logic [3:0] Pos1   = 4'd0;
  logic [7:0] X1;
  logic [6:0] Y1;
  logic [2:0] C1;
  logic       P1, B1, D1;

  int   total    = 0;
  int   bad      = 0;
  int   plot_cnt = 0;
  int   done_cnt = 0;
  pix_t exp_q[$];

  always #5 Clock = ~Clock;

  sprite_lane_drawer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .Pos(Pos),
    .XOut(XOut), .YOut(YOut), .Color(Color), .Plot(Plot), .Busy(Busy), .Done(Done)
  );

  sprite_lane_drawer #(.SPR_W(1), .SPR_H(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(Start1), .Op(Op1), .Pos(Pos1),
    .XOut(X1), .YOut(Y1), .Color(C1), .Plot(P1), .Busy(B1), .Done(D1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rect(input logic [7:0] bx, input logic [2:0] c);
    pix_t p;
    for (int yy = 0; yy < 5; yy++) begin
      for (int xx = 0; xx < 9; xx++) begin
        p.x = bx + 8'(xx);
        p.y = 7'd102 + 7'(yy);
        p.c = c;
        exp_q.push_back(p);
      end
    end
  endtask

  always @(negedge Clock) begin
    pix_t e;
    if (Done) done_cnt++;
    if (Plot) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", 32'({XOut, YOut, Color}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", 32'({XOut, YOut, Color}), 32'(e));
      end
    end
  end

  // Called on a negedge; the request is accepted on the following rising edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] pos,
                        input int exp_len, input int exp_plots, input bit poke);
    int cyc;
    int p0;
    int d0;
    p0 = plot_cnt;
    d0 = done_cnt;
    Start = 1'b1;
    Op    = op;
    Pos   = pos;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Op    = 2'($urandom);
    Pos   = 4'($urandom);
    @(negedge Clock);
    cyc = 1;
    chk({tag, "_busy1"}, 32'(Busy), 32'd1);
    while (!Done && cyc < 300) begin
      if (poke) begin
        Start = 1'b1;
        Op    = 2'b10;
        Pos   = 4'd0;
      end
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_len));
    chk({tag, "_plots"}, 32'(plot_cnt - p0), 32'(exp_plots));
    @(negedge Clock);
    chk({tag, "_idle"}, 32'({Busy, Done, Plot}), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    chk("reset_outputs", 32'({XOut, YOut, Color, Plot, Busy, Done}), 32'd0);
    chk("reset_outputs_w1", 32'({X1, Y1, C1, P1, B1, D1}), 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    run_op("erase_nothing", 2'b01, 4'd0, 1, 0, 1'b0);

    push_rect(8'd78, 3'b011);
    run_op("draw_pos2", 2'b00, 4'd2, 46, 45, 1'b0);

    push_rect(8'd78, 3'b000);
    push_rect(8'd6, 3'b011);
    run_op("move_2_to_0", 2'b10, 4'd0, 91, 90, 1'b0);

    push_rect(8'd6, 3'b000);
    run_op("erase_pos0", 2'b01, 4'd7, 46, 45, 1'b0);

    push_rect(8'd132, 3'b011);
    run_op("draw_pos9_clamp", 2'b00, 4'd9, 46, 45, 1'b0);

    push_rect(8'd24, 3'b011);
    run_op("op11_draw_pos1", 2'b11, 4'd1, 46, 45, 1'b0);

    push_rect(8'd24, 3'b000);
    push_rect(8'd132, 3'b011);
    run_op("move_1_to_15", 2'b10, 4'd15, 91, 90, 1'b0);

    push_rect(8'd132, 3'b000);
    run_op("erase_pos3", 2'b01, 4'd0, 46, 45, 1'b0);

    push_rect(8'd132, 3'b011);
    run_op("move_no_last", 2'b10, 4'd3, 46, 45, 1'b0);

    push_rect(8'd78, 3'b011);
    run_op("draw_with_pokes", 2'b00, 4'd2, 46, 45, 1'b1);

    push_rect(8'd78, 3'b011);
    Start = 1'b1;
    Op    = 2'b00;
    Pos   = 4'd2;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (20) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("reset_mid_plot_busy", 32'({Plot, Busy}), 32'd0);
    chk("reset_mid_pixels_left", 32'(exp_q.size()), 32'd25);
    exp_q.delete();
    Reset = 1'b1;
    @(negedge Clock);
    run_op("erase_after_reset", 2'b01, 4'd2, 1, 0, 1'b0);

    Start1 = 1'b1;
    Op1    = 2'b00;
    Pos1   = 4'd1;
    @(posedge Clock);
    #1;
    Start1 = 1'b0;
    @(negedge Clock);
    chk("w1_pixel", 32'({P1, X1, Y1, C1}), 32'({1'b1, 8'd24, 7'd102, 3'b011}));
    @(negedge Clock);
    chk("w1_done", 32'({P1, D1, B1}), 32'b011);
    @(negedge Clock);
    chk("w1_idle", 32'({P1, D1, B1}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
